w5300_socket_bank_conf: RTL and testbench



---
 rtl/w5300_socket_bank_conf.sv | 247 ++++++++++++++++++++++++
 tb/tb_w5300_socket_bank_conf.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_socket_bank_conf.sv
// w5300_socket_bank_conf
// Brings up sockets 0..NUM_SOCKETS-1 on a W5300 one after another, each as a
// TCP server or a UDP socket, over the shared single-transaction register bus.
// Every socket gets MAX_RETRY close/reopen retries after a poll timeout, and the
// block reports which sockets came up (sock_ok) and which gave up (sock_fail).
// Bus address format: addr[10] = 1 for a write, 0 for a read; addr[9:0] = register.
module w5300_socket_bank_conf #(
    parameter int unsigned NUM_SOCKETS = 2,
    parameter logic [15:0] BASE_PORT   = 16'd7000,
    parameter logic [7:0]  UDP_MASK    = 8'h00,
    parameter logic [15:0] OP_TIMEOUT  = 16'd100,
    parameter logic [3:0]  MAX_RETRY   = 4'd2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   op_state,
    input  logic [15:0]            rd_data,
    output logic [10:0]            addr,
    output logic [15:0]            wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_SOCKETS-1:0] sock_ok,
    output logic [NUM_SOCKETS-1:0] sock_fail
);

    localparam logic FLAG_WR = 1'b1;
    localparam logic FLAG_RD = 1'b0;

    // Socket 0 register addresses; socket n sits 0x40 above socket n-1.
    localparam logic [9:0] S0_MR             = 10'h200;
    localparam logic [9:0] S0_CR             = 10'h202;
    localparam logic [9:0] S0_IMR            = 10'h204;
    localparam logic [9:0] S0_SSR            = 10'h208;
    localparam logic [9:0] S0_PORTR          = 10'h20A;
    localparam logic [9:0] S0_KPALVTR_PROTOR = 10'h21A;

    localparam logic [15:0] MR_TCP     = 16'h0001;
    localparam logic [15:0] MR_UDP     = 16'h0002;
    localparam logic [15:0] IMR_VALUE  = 16'h001F;  // SENDOK|TIMEOUT|RECV|DISCON|CON
    localparam logic [15:0] KPALV_PROT = {8'd1, 8'd1};
    localparam logic [15:0] CR_OPEN    = 16'h0001;
    localparam logic [15:0] CR_LISTEN  = 16'h0002;
    localparam logic [15:0] CR_CLOSE   = 16'h0010;

    localparam logic [7:0] SOCK_INIT   = 8'h13;
    localparam logic [7:0] SOCK_LISTEN = 8'h14;
    localparam logic [7:0] SOCK_UDP    = 8'h22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAMS,
        S_POLL_OPEN,
        S_LISTEN,
        S_POLL_LISTEN,
        S_CLOSE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   state, state_n;
    logic [2:0]               sidx, sidx_n;
    logic [2:0]               op_idx, op_idx_n;
    logic [3:0]               retry, retry_n;
    logic [15:0]              tick, tick_n;
    logic [NUM_SOCKETS-1:0]   ok_n, fail_n;
    logic [NUM_SOCKETS-1:0]   sock_sel;
    logic                     is_udp;
    logic                     in_poll;
    logic [7:0]               ssr_target;
    logic                     poll_hit;
    logic                     poll_expired;
    logic                     unused_rd_hi;

    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] base, input logic [2:0] n);
        return base + {1'b0, n, 6'b0};
    endfunction

    // Only the low byte of SSR carries the socket state.
    assign unused_rd_hi = ^rd_data[15:8];

    assign sock_sel     = NUM_SOCKETS'(1) << sidx;
    assign is_udp       = UDP_MASK[sidx];
    assign in_poll      = (state == S_POLL_OPEN) || (state == S_POLL_LISTEN);
    assign ssr_target   = (state == S_POLL_LISTEN) ? SOCK_LISTEN :
                          (is_udp ? SOCK_UDP : SOCK_INIT);
    assign poll_hit     = in_poll && op_state && (rd_data[7:0] == ssr_target);
    assign poll_expired = in_poll && (tick == OP_TIMEOUT);

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    // State, counters and status vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sidx      <= 3'd0;
            op_idx    <= 3'd0;
            retry     <= 4'd0;
            tick      <= 16'd0;
            sock_ok   <= '0;
            sock_fail <= '0;
        end else begin
            state     <= state_n;
            sidx      <= sidx_n;
            op_idx    <= op_idx_n;
            retry     <= retry_n;
            tick      <= tick_n;
            sock_ok   <= ok_n;
            sock_fail <= fail_n;
        end
    end

    // Next-state logic: sequencing, retries and status updates.
    always_comb begin
        state_n  = state;
        sidx_n   = sidx;
        op_idx_n = op_idx;
        retry_n  = retry;
        ok_n     = sock_ok;
        fail_n   = sock_fail;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n  = S_PARAMS;
                    sidx_n   = 3'd0;
                    op_idx_n = 3'd0;
                    retry_n  = 4'd0;
                end
            end
            S_PARAMS: begin
                if (op_state) begin
                    if (op_idx == 3'd4) state_n = S_POLL_OPEN;
                    else                op_idx_n = op_idx + 3'd1;
                end
            end
            S_POLL_OPEN: begin
                if (poll_hit) begin
                    if (is_udp) begin
                        ok_n    = sock_ok | sock_sel;
                        state_n = S_NEXT;
                    end else begin
                        state_n = S_LISTEN;
                    end
                end else if (poll_expired) begin
                    state_n = S_CLOSE;
                end
            end
            S_LISTEN: begin
                if (op_state) state_n = S_POLL_LISTEN;
            end
            S_POLL_LISTEN: begin
                if (poll_hit) begin
                    ok_n    = sock_ok | sock_sel;
                    state_n = S_NEXT;
                end else if (poll_expired) begin
                    state_n = S_CLOSE;
                end
            end
            S_CLOSE: begin
                if (op_state) begin
                    if (retry == MAX_RETRY) begin
                        fail_n  = sock_fail | sock_sel;
                        state_n = S_NEXT;
                    end else begin
                        retry_n  = retry + 4'd1;
                        op_idx_n = 3'd0;
                        state_n  = S_PARAMS;
                    end
                end
            end
            S_NEXT: begin
                retry_n  = 4'd0;
                op_idx_n = 3'd0;
                if (sidx == 3'(NUM_SOCKETS - 1)) begin
                    state_n = S_DONE;
                end else begin
                    sidx_n  = sidx + 3'd1;
                    state_n = S_PARAMS;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    ok_n    = '0;
                    fail_n  = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Poll budget restarts on every poll entry and saturates at the limit.
        tick_n = 16'd0;
        if (in_poll && (state_n == state)) begin
            tick_n = (tick == OP_TIMEOUT) ? tick : tick + 16'd1;
        end
    end

    // Bus transaction presented for the current state and op.
    always_comb begin
        addr    = {FLAG_RD, 10'h000};
        wr_data = 16'h0000;
        case (state)
            S_PARAMS: begin
                case (op_idx)
                    3'd0: begin
                        addr    = {FLAG_WR, get_socket_n_reg(S0_MR, sidx)};
                        wr_data = is_udp ? MR_UDP : MR_TCP;
                    end
                    3'd1: begin
                        addr    = {FLAG_WR, get_socket_n_reg(S0_PORTR, sidx)};
                        wr_data = BASE_PORT + {13'd0, sidx};
                    end
                    3'd2: begin
                        addr    = {FLAG_WR, get_socket_n_reg(S0_IMR, sidx)};
                        wr_data = IMR_VALUE;
                    end
                    3'd3: begin
                        addr    = {FLAG_WR, get_socket_n_reg(S0_KPALVTR_PROTOR, sidx)};
                        wr_data = KPALV_PROT;
                    end
                    default: begin
                        addr    = {FLAG_WR, get_socket_n_reg(S0_CR, sidx)};
                        wr_data = CR_OPEN;
                    end
                endcase
            end
            S_POLL_OPEN, S_POLL_LISTEN: begin
                addr = {FLAG_RD, get_socket_n_reg(S0_SSR, sidx)};
            end
            S_LISTEN: begin
                addr    = {FLAG_WR, get_socket_n_reg(S0_CR, sidx)};
                wr_data = CR_LISTEN;
            end
            S_CLOSE: begin
                addr    = {FLAG_WR, get_socket_n_reg(S0_CR, sidx)};
                wr_data = CR_CLOSE;
            end
            default: begin
                addr    = {FLAG_RD, 10'h000};
                wr_data = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_w5300_socket_bank_conf.sv
// Bench for w5300_socket_bank_conf: acts as the W5300 bus engine with random
// latencies and SSR answers, and checks against a transaction-level model.
module tb_w5300_socket_bank_conf;

    localparam int          NS   = 2;
    localparam logic [15:0] BASE = 16'hFFFF;
    localparam logic [7:0]  MASK = 8'h02;
    localparam int          TO   = 12;
    localparam int          MAXR = 2;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            enable   = 1'b0;
    logic            op_state = 1'b0;
    logic [15:0]     rd_data  = 16'h0;
    logic [10:0]     addr;
    logic [15:0]     wr_data;
    logic            busy;
    logic            done;
    logic [NS-1:0]   sock_ok;
    logic [NS-1:0]   sock_fail;

    int tests = 0;
    int fails = 0;

    w5300_socket_bank_conf #(
        .NUM_SOCKETS(NS),
        .BASE_PORT  (BASE),
        .UDP_MASK   (MASK),
        .OP_TIMEOUT (16'(TO)),
        .MAX_RETRY  (4'(MAXR))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .op_state (op_state),
        .rd_data  (rd_data),
        .addr     (addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .sock_ok  (sock_ok),
        .sock_fail(sock_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] a;
        logic [15:0] v;
    } wr_t;

    typedef struct {
        int          d;      // op_state cycle carrying the match, -1 = never matches
        logic [7:0]  tgt;
        logic [10:0] a;
    } ph_t;

    wr_t           wr_q[$];
    ph_t           ph_q[$];
    logic [NS-1:0] exp_ok;
    logic [NS-1:0] exp_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] reg_a(input logic wr, input int s, input int off);
        return {wr, 10'(512 + 64 * s + off)};
    endfunction

    function automatic logic [7:0] other(input logic [7:0] t);
        logic [7:0] v;
        v = 8'($urandom);
        if (v == t) v = v ^ 8'h01;
        return v;
    endfunction

    // Outcome of one poll phase for a scenario.
    function automatic int outcome(input int scen, input int s, input int a, input bit lis);
        if (scen == 0 && s == 0) begin
            if (a == 0 && !lis) return -1;
            if (lis) return TO;
            return int'($urandom_range(0, TO));
        end
        if (scen == 1 && s == 0) return -1;
        if (scen < 2) return int'($urandom_range(0, TO));
        if ($urandom_range(0, 3) == 0) return -1;
        return int'($urandom_range(0, TO));
    endfunction

    // Expected write stream, poll phases and final status for a scenario.
    function automatic void build_model(input int scen);
        bit udp;
        bit settled;
        int d;
        wr_q.delete();
        ph_q.delete();
        exp_ok   = '0;
        exp_fail = '0;
        for (int s = 0; s < NS; s++) begin
            udp     = ((int'(MASK) >> s) & 1) == 1;
            settled = 1'b0;
            for (int a = 0; a <= MAXR && !settled; a++) begin
                wr_q.push_back('{reg_a(1'b1, s, 'h00), udp ? 16'h0002 : 16'h0001});
                wr_q.push_back('{reg_a(1'b1, s, 'h0A), 16'(int'(BASE) + s)});
                wr_q.push_back('{reg_a(1'b1, s, 'h04), 16'h001F});
                wr_q.push_back('{reg_a(1'b1, s, 'h1A), 16'h0101});
                wr_q.push_back('{reg_a(1'b1, s, 'h02), 16'h0001});
                d = outcome(scen, s, a, 1'b0);
                ph_q.push_back('{d, udp ? 8'h22 : 8'h13, reg_a(1'b0, s, 'h08)});
                if (d >= 0 && !udp) begin
                    wr_q.push_back('{reg_a(1'b1, s, 'h02), 16'h0002});
                    d = outcome(scen, s, a, 1'b1);
                    ph_q.push_back('{d, 8'h14, reg_a(1'b0, s, 'h08)});
                end
                if (d < 0) begin
                    wr_q.push_back('{reg_a(1'b1, s, 'h02), 16'h0010});
                    if (a == MAXR) exp_fail = exp_fail | (NS'(1) << s);
                end else begin
                    exp_ok  = exp_ok | (NS'(1) << s);
                    settled = 1'b1;
                end
            end
        end
    endfunction

    // Bus engine: answers transactions until done, budget expiry or abort point.
    task automatic run_seq(input bit abort_listen, output bit aborted);
        int  wait_w;
        bit  in_poll;
        int  age;
        int  cyc;
        int  next_cnt;
        bit  was_next;
        bit  is_poll;
        int  mask;
        ph_t ph;
        wr_t w;
        wait_w   = -1;
        in_poll  = 1'b0;
        age      = 0;
        cyc      = 0;
        next_cnt = 0;
        was_next = 1'b0;
        aborted  = 1'b0;
        ph       = '{-1, 8'h00, 11'h000};
        forever begin
            @(negedge clk);
            op_state = 1'b0;
            rd_data  = 16'($urandom);
            cyc++;
            if (cyc > 5000) begin
                check("cycle_budget", 32'd0, 32'd1);
                return;
            end
            is_poll = busy && !addr[10] && (addr[9:0] != 10'h000);
            if (in_poll) begin
                age++;
                if (!is_poll) begin
                    check("poll_len", age, (ph.d < 0) ? TO + 1 : ph.d + 1);
                    in_poll = 1'b0;
                end
            end
            if (!in_poll && is_poll) begin
                if (ph_q.size() == 0) begin
                    check("extra_poll", 32'd1, 32'd0);
                    return;
                end
                ph = ph_q.pop_front();
                check("ssr_addr", addr, ph.a);
                in_poll = 1'b1;
                age     = 0;
            end
            if (!busy) check("idle_bus", {addr, wr_data}, 32'd0);
            if (done) begin
                check("done_after_next", was_next, 32'd1);
                return;
            end
            was_next = 1'b0;
            if (busy && addr == 11'h000) begin
                mask = (next_cnt < 31) ? ((1 << (next_cnt + 1)) - 1) : -1;
                check("next_ok", sock_ok, int'(exp_ok) & mask);
                check("next_fail", sock_fail, int'(exp_fail) & mask);
                check("next_wdata", wr_data, 32'd0);
                next_cnt++;
                was_next = 1'b1;
            end
            if (in_poll) begin
                if (abort_listen && ph.tgt == 8'h14 && age == 3) begin
                    aborted = 1'b1;
                    return;
                end
                if (ph.d >= 0 && age == ph.d) begin
                    op_state     = 1'b1;
                    rd_data[7:0] = ph.tgt;
                end else if ((ph.d < 0 || age < ph.d) && $urandom_range(0, 3) == 0) begin
                    op_state     = 1'b1;
                    rd_data[7:0] = other(ph.tgt);
                end
            end else if (busy && addr[10]) begin
                if (wait_w < 0) wait_w = int'($urandom_range(0, 2));
                if (wait_w == 0) begin
                    op_state = 1'b1;
                    wait_w   = -1;
                    if (wr_q.size() == 0) begin
                        check("extra_write", 32'd1, 32'd0);
                        return;
                    end
                    w = wr_q.pop_front();
                    check("wr_addr", addr, w.a);
                    check("wr_data", wr_data, w.v);
                end else begin
                    wait_w--;
                end
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_ok"}, sock_ok, 32'd0);
        check({tag, "_fail"}, sock_fail, 32'd0);
        check({tag, "_addr"}, addr, 32'd0);
        check({tag, "_wdata"}, wr_data, 32'd0);
    endtask

    // One full sequence from Idle to Done, hold, then re-arm by dropping enable.
    task automatic do_run(input int scen);
        bit ab;
        build_model(scen);
        enable = 1'b1;
        run_seq(1'b0, ab);
        op_state = 1'b0;
        check("final_done", done, 32'd1);
        check("final_ok", sock_ok, exp_ok);
        check("final_fail", sock_fail, exp_fail);
        check("writes_left", wr_q.size(), 32'd0);
        check("polls_left", ph_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_done", done, 32'd1);
        check("hold_ok", sock_ok, exp_ok);
        check("hold_fail", sock_fail, exp_fail);
        enable = 1'b0;
        @(negedge clk);
        check_reset("rearm");
        @(negedge clk);
    endtask

    initial begin
        bit ab;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Retry then pass on socket 0, match exactly at the poll limit,
        // UDP socket 1 with wrapped port.
        do_run(0);

        // Socket 0 never opens: full retry exhaustion, socket 1 still configured.
        do_run(1);

        // Reset in the middle of a listen poll, then a clean rerun.
        build_model(0);
        enable = 1'b1;
        run_seq(1'b1, ab);
        op_state = 1'b0;
        check("abort_reached", ab, 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        @(negedge clk);
        do_run(0);

        // Random timeouts and match delays.
        for (int i = 0; i < 4; i++) do_run(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
